// File: rtl/bram_pkg.sv
// Shared constants for the dual-port BRAM arbiter: FSM state encoding and port indices.
package bram_pkg;

  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_lock_sel.sv
// Round-robin grant selection with bounded exclusive lock ownership.
import bram_pkg::*;

module rr_lock_sel #(
  parameter int LOCK_MAX = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic p0_req,
  input  logic p1_req,
  input  logic p0_lock,
  input  logic p1_lock,
  output logic p0_grant,
  output logic p1_grant
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       last_grant_r;
  logic       last_grant_nxt_s;
  logic [7:0] lock_cnt_r;
  logic [7:0] lock_cnt_nxt_s;

  // Grant decode: a tie goes to the port that did not win last time
  always_comb begin
    p0_grant = 1'b0;
    p1_grant = 1'b0;
    case (state_r)
      ARB: begin
        if (p0_req && p1_req) begin
          p0_grant = (last_grant_r == PORT1);
          p1_grant = (last_grant_r == PORT0);
        end else begin
          p0_grant = p0_req;
          p1_grant = p1_req;
        end
      end
      LOCK0:   p0_grant = p0_req;
      LOCK1:   p1_grant = p1_req;
      default: begin
        p0_grant = 1'b0;
        p1_grant = 1'b0;
      end
    endcase
  end

  // Next-state: lock entry on a locking grant, exit on lock release or budget expiry
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    lock_cnt_nxt_s   = lock_cnt_r;
    case (state_r)
      ARB: begin
        if (p0_grant) begin
          last_grant_nxt_s = PORT0;
          if (p0_lock) begin
            state_nxt_s    = LOCK0;
            lock_cnt_nxt_s = 8'd0;
          end else begin
            state_nxt_s = ARB;
          end
        end else if (p1_grant) begin
          last_grant_nxt_s = PORT1;
          if (p1_lock) begin
            state_nxt_s    = LOCK1;
            lock_cnt_nxt_s = 8'd0;
          end else begin
            state_nxt_s = ARB;
          end
        end else begin
          state_nxt_s = ARB;
        end
      end
      LOCK0: begin
        lock_cnt_nxt_s   = lock_cnt_r + 8'd1;
        last_grant_nxt_s = PORT0;
        if ((lock_cnt_r == LOCK_LAST) || !p0_lock) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = LOCK0;
        end
      end
      LOCK1: begin
        lock_cnt_nxt_s   = lock_cnt_r + 8'd1;
        last_grant_nxt_s = PORT1;
        if ((lock_cnt_r == LOCK_LAST) || !p1_lock) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = LOCK1;
        end
      end
      default: begin
        state_nxt_s    = ARB;
        lock_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Arbitration state registers; reset makes port 0 win the first tie
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ARB;
      last_grant_r <= PORT1;
      lock_cnt_r   <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      lock_cnt_r   <= lock_cnt_nxt_s;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port BRAM with registered read data.
import bram_pkg::*;

module bram_arbiter #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9,
  parameter int LOCK_MAX      = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic                     p0_lock,
  input  logic [RAM_ADDR_BITS-1:0] p0_addr,
  input  logic [RAM_WIDTH-1:0]     p0_wdata,
  output logic                     p0_ack,
  output logic                     p0_rvalid,
  output logic [RAM_WIDTH-1:0]     p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic                     p1_lock,
  input  logic [RAM_ADDR_BITS-1:0] p1_addr,
  input  logic [RAM_WIDTH-1:0]     p1_wdata,
  output logic                     p1_ack,
  output logic                     p1_rvalid,
  output logic [RAM_WIDTH-1:0]     p1_rdata,
  output logic                     ram_enable,
  output logic                     ram_write_enable,
  output logic [RAM_ADDR_BITS-1:0] ram_address,
  output logic [RAM_WIDTH-1:0]     ram_input_data,
  input  logic [RAM_WIDTH-1:0]     ram_output_data
);

  logic grant0_s;
  logic grant1_s;
  logic rd0_r;
  logic rd1_r;

  rr_lock_sel #(.LOCK_MAX(LOCK_MAX)) u_sel (
    .clock    (clock),
    .reset_n  (reset_n),
    .p0_req   (p0_req),
    .p1_req   (p1_req),
    .p0_lock  (p0_lock),
    .p1_lock  (p1_lock),
    .p0_grant (grant0_s),
    .p1_grant (grant1_s)
  );

  assign p0_ack    = grant0_s;
  assign p1_ack    = grant1_s;
  assign p0_rvalid = rd0_r;
  assign p1_rvalid = rd1_r;
  assign p0_rdata  = rd0_r ? ram_output_data : {RAM_WIDTH{1'b0}};
  assign p1_rdata  = rd1_r ? ram_output_data : {RAM_WIDTH{1'b0}};

  // Memory request mux from the acknowledged port
  always_comb begin
    ram_enable       = 1'b0;
    ram_write_enable = 1'b0;
    ram_address      = {RAM_ADDR_BITS{1'b0}};
    ram_input_data   = {RAM_WIDTH{1'b0}};
    if (grant0_s) begin
      ram_enable       = 1'b1;
      ram_write_enable = p0_we;
      ram_address      = p0_addr;
      ram_input_data   = p0_wdata;
    end else if (grant1_s) begin
      ram_enable       = 1'b1;
      ram_write_enable = p1_we;
      ram_address      = p1_addr;
      ram_input_data   = p1_wdata;
    end else begin
      ram_enable       = 1'b0;
      ram_write_enable = 1'b0;
    end
  end

  // Read-return tracking matches the one-cycle RAM read latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd0_r <= 1'b0;
      rd1_r <= 1'b0;
    end else begin
      rd0_r <= grant0_s & ~p0_we;
      rd1_r <= grant1_s & ~p1_we;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed scoreboard bench for bram_arbiter with a behavioural BRAM model.
module tb_bram_arbiter;

  logic        clock;
  logic        reset_n;
  logic        p0_req, p0_we, p0_lock, p0_ack, p0_rvalid;
  logic [8:0]  p0_addr;
  logic [31:0] p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_lock, p1_ack, p1_rvalid;
  logic [8:0]  p1_addr;
  logic [31:0] p1_wdata, p1_rdata;
  logic        ram_enable, ram_write_enable;
  logic [8:0]  ram_address;
  logic [31:0] ram_input_data;
  logic [31:0] ram_output_data;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  // Stored as delta against a per-address pattern so all-zero init is meaningful
  logic [31:0] mem    [512] = '{default: 32'h0};
  logic [31:0] sh_mem [512] = '{default: 32'h0};

  bram_arbiter dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .p0_req           (p0_req),
    .p0_we            (p0_we),
    .p0_lock          (p0_lock),
    .p0_addr          (p0_addr),
    .p0_wdata         (p0_wdata),
    .p0_ack           (p0_ack),
    .p0_rvalid        (p0_rvalid),
    .p0_rdata         (p0_rdata),
    .p1_req           (p1_req),
    .p1_we            (p1_we),
    .p1_lock          (p1_lock),
    .p1_addr          (p1_addr),
    .p1_wdata         (p1_wdata),
    .p1_ack           (p1_ack),
    .p1_rvalid        (p1_rvalid),
    .p1_rdata         (p1_rdata),
    .ram_enable       (ram_enable),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_input_data   (ram_input_data),
    .ram_output_data  (ram_output_data)
  );

  function automatic logic [31:0] pat(input logic [8:0] a);
    return 32'hA500_0000 | {23'h0, a};
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BRAM model: registered read, write-through storage
  always @(posedge clock) begin
    if (ram_enable) begin
      if (ram_write_enable) mem[ram_address] <= ram_input_data ^ pat(ram_address);
      else ram_output_data <= mem[ram_address] ^ pat(ram_address);
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0, input logic [8:0] a0,
                       input logic [31:0] d0, input logic r1, input logic l1, input logic [8:0] a1);
    p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = 1'b0; p1_lock = l1; p1_addr = a1; p1_wdata = 32'h0;
  endtask

  // One cycle: check returning read data, then this cycle's grant and RAM request
  task automatic cycle(input logic e0, input logic e1);
    sb_t item;
    @(negedge clock);
    if (sb_q.size() != 0) begin
      item = sb_q.pop_front();
      chk1("rvalid_p0", p0_rvalid, item.port == 1'b0);
      chk1("rvalid_p1", p1_rvalid, item.port == 1'b1);
      chk32("rdata", item.port ? p1_rdata : p0_rdata, item.data);
      chk32("rdata_idle", item.port ? p0_rdata : p1_rdata, 32'h0);
    end else begin
      chk1("no_rvalid_p0", p0_rvalid, 1'b0);
      chk1("no_rvalid_p1", p1_rvalid, 1'b0);
      chk32("zero_rdata_p0", p0_rdata, 32'h0);
      chk32("zero_rdata_p1", p1_rdata, 32'h0);
    end
    chk1("p0_ack", p0_ack, e0);
    chk1("p1_ack", p1_ack, e1);
    chk1("ram_enable", ram_enable, e0 | e1);
    if (e0) begin
      chk32("ram_address_p0", {23'h0, ram_address}, {23'h0, p0_addr});
      chk1("ram_we_p0", ram_write_enable, p0_we);
      if (p0_we) begin
        chk32("ram_wdata_p0", ram_input_data, p0_wdata);
        sh_mem[p0_addr] = p0_wdata ^ pat(p0_addr);
      end else begin
        sb_q.push_back('{port: 1'b0, data: sh_mem[p0_addr] ^ pat(p0_addr)});
      end
    end else if (e1) begin
      chk32("ram_address_p1", {23'h0, ram_address}, {23'h0, p1_addr});
      chk1("ram_we_p1", ram_write_enable, 1'b0);
      sb_q.push_back('{port: 1'b1, data: sh_mem[p1_addr] ^ pat(p1_addr)});
    end else begin
      chk1("ram_we_idle", ram_write_enable, 1'b0);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 9'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk1("reset_rvalid_p0", p0_rvalid, 1'b0);
    chk1("reset_rvalid_p1", p1_rvalid, 1'b0);
    chk1("reset_ram_enable", ram_enable, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Alternating back-to-back reads from reset
    drive(1'b1, 1'b0, 1'b0, 9'd5, 32'h0, 1'b1, 1'b0, 9'd6);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 9'd0);
    cycle(1'b0, 1'b0);

    // Write then read-back on the other port
    drive(1'b1, 1'b1, 1'b0, 9'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 9'd0);
    cycle(1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 9'd0, 32'h0, 1'b1, 1'b0, 9'd3);
    cycle(1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 9'd0);
    cycle(1'b0, 1'b0);

    // p1 holds lock to expiry while p0 waits
    drive(1'b0, 1'b0, 1'b0, 9'd0, 32'h0, 1'b1, 1'b1, 9'd7);
    cycle(1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 9'd8, 32'h0, 1'b1, 1'b1, 9'd7);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 9'd0);
    cycle(1'b0, 1'b0);

    // p0 locks for three accesses, then waiting p1 wins
    drive(1'b1, 1'b0, 1'b1, 9'd10, 32'h0, 1'b0, 1'b0, 9'd9);
    cycle(1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 9'd10, 32'h0, 1'b1, 1'b0, 9'd9);
    cycle(1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 9'd10, 32'h0, 1'b1, 1'b0, 9'd9);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 9'd0);
    cycle(1'b0, 1'b0);

    // Reset with a p0 read in flight discards it and restores p0 tie priority
    drive(1'b1, 1'b0, 1'b0, 9'd11, 32'h0, 1'b0, 1'b0, 9'd0);
    cycle(1'b1, 1'b0);
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 9'd0);
    sb_q.delete();
    cycle(1'b0, 1'b0);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 9'd12, 32'h0, 1'b1, 1'b0, 9'd13);
    cycle(1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 9'd0);
    cycle(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The module SHALL have parameter RAM_WIDTH, default 32, data word width.
REQ-002 The module SHALL have parameter RAM_ADDR_BITS, default 9, word address width.
REQ-003 The module SHALL have parameter LOCK_MAX, default 16, maximum consecutive cycles one requester may hold a lock; legal range 2..255.
REQ-004 The module SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The module SHALL have ports p0_req / p1_req, input, 1, access request held until acknowledged.
REQ-007 The module SHALL have ports p0_we / p1_we, input, 1, 1=write, 0=read; qualified by req.
REQ-008 The module SHALL have ports p0_lock / p1_lock, input, 1, request exclusive ownership after this access.
REQ-009 The module SHALL have ports p0_addr / p1_addr, input, RAM_ADDR_BITS, word address.
REQ-010 The module SHALL have ports p0_wdata / p1_wdata, input, RAM_WIDTH, write data.
REQ-011 The module SHALL have ports p0_ack / p1_ack, output, 1, access accepted this cycle.
REQ-012 The module SHALL have ports p0_rvalid / p1_rvalid, output, 1, read data valid this cycle.
REQ-013 The module SHALL have ports p0_rdata / p1_rdata, output, RAM_WIDTH, read data.
REQ-014 The module SHALL have port ram_enable, output, 1, memory enable.
REQ-015 The module SHALL have port ram_write_enable, output, 1, memory write strobe.
REQ-016 The module SHALL have port ram_address, output, RAM_ADDR_BITS, memory address.
REQ-017 The module SHALL have port ram_input_data, output, RAM_WIDTH, memory write data.
REQ-018 The module SHALL have port ram_output_data, input, RAM_WIDTH, memory read data, registered, valid one cycle after enable.

Function
REQ-019 The module SHALL accept at most one access per cycle; pX_ack is combinational from current req/state and is never asserted for both ports.
REQ-020 In an accepting cycle the module SHALL drive ram_enable=1, with ram_write_enable, ram_address and ram_input_data taken from the acknowledged port; otherwise ram_enable=0 and ram_write_enable=0.
REQ-021 The FSM SHALL have states ARB, LOCK0, LOCK1.
REQ-022 In ARB: single requester granted; both requesting -> grant the port not in register last_grant (round-robin); last_grant updated on every ack.
REQ-023 An ack in ARB with pX_lock=1 SHALL move the FSM to LOCKX and clear lock_cnt.
REQ-024 In LOCKX only port X SHALL be acknowledged (whenever pX_req=1); the other port stalls with ack=0.
REQ-025 In LOCKX, a cycle with pX_lock=0 SHALL return the FSM to ARB at the next edge; that cycle still grants X exclusively.
REQ-026 lock_cnt SHALL increment every LOCKX cycle; at lock_cnt=LOCK_MAX-1 the FSM SHALL return to ARB with last_grant=X regardless of pX_lock.
REQ-027 For an acknowledged read, pX_rvalid SHALL assert exactly one cycle later, for one cycle, with pX_rdata=ram_output_data; writes produce no rvalid.
REQ-028 pX_rdata SHALL be ram_output_data when pX_rvalid=1 and all-zero otherwise.
REQ-029 Back-to-back reads from alternating ports SHALL sustain one access per cycle with each rvalid routed to the correct port.

Reset
REQ-030 reset_n low SHALL asynchronously force FSM=ARB, last_grant=1 (port 0 wins first tie), lock_cnt=0, all pX_rvalid=0.
REQ-031 Reset mid-lock or with a read in flight SHALL discard the pending rvalid; memory contents are unaffected by the arbiter.

Structure
REQ-032 The FSM state encoding and port-index constants SHALL live in shared package bram_pkg.
REQ-033 The round-robin/lock selection SHALL be one natural sub-module, rr_lock_sel; the memory itself stays outside this module.

Verification
REQ-034 Both ports read addr 5 and 6 every cycle from reset -> acks alternate p0,p1,p0...; rvalid follows each ack by one cycle with the matching data.
REQ-035 p0 writes 0xDEADBEEF to addr 3, then p1 reads addr 3 -> p1_rvalid with rdata 0xDEADBEEF; no rvalid for the write.
REQ-036 p1 acquires lock, p0 requesting throughout, p1_lock held -> p0_ack=0 for exactly 16 cycles, then p0 acknowledged.
REQ-037 p0 lock dropped after 3 accesses -> FSM back to ARB; waiting p1 acknowledged on next cycle.
REQ-038 reset_n pulsed low the cycle after a p0 read ack -> no p0_rvalid; first post-reset tie grants p0.
